slab_interval_reduce: RTL and testbench

SLAB_INTERVAL_REDUCE -- requirements
Module: slab_interval_reduce

---
 rtl/raabb_fp_pkg.sv | 37 +++
 rtl/slab_interval_reduce_if.sv | 28 ++
 rtl/fp_order_le.sv | 35 +++
 rtl/slab_interval_reduce.sv | 115 +++++++++++
 tb/tb_slab_interval_reduce.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/raabb_fp_pkg.sv
// Shared FP word definitions for the ray/AABB slab pipeline: default field widths,
// exception encodings, the total-order rank of each value class and the reducer state type.
package raabb_fp_pkg;

    localparam int FP_WE    = 11;
    localparam int FP_WF    = 11;
    localparam int FP_WIDTH = FP_WE + FP_WF + 2;

    localparam logic [1:0] EXC_ZERO = 2'b00;
    localparam logic [1:0] EXC_NORM = 2'b01;
    localparam logic [1:0] EXC_INF  = 2'b10;
    localparam logic [1:0] EXC_NAN  = 2'b11;

    localparam logic [2:0] RANK_NEG_INF  = 3'd0;
    localparam logic [2:0] RANK_NEG_NORM = 3'd1;
    localparam logic [2:0] RANK_ZERO     = 3'd2;
    localparam logic [2:0] RANK_POS_NORM = 3'd3;
    localparam logic [2:0] RANK_POS_INF  = 3'd4;
    localparam logic [2:0] RANK_NAN      = 3'd5;

    typedef logic [0:0] state_t;
    localparam state_t ST_ACC  = 1'b0;
    localparam state_t ST_EMIT = 1'b1;

    // Zeros of either sign share a rank, and every NaN sits above +inf.
    function automatic logic [2:0] fp_rank(input logic [1:0] exc, input logic sign);
        logic [2:0] r;
        case (exc)
            EXC_ZERO: r = RANK_ZERO;
            EXC_NORM: r = sign ? RANK_NEG_NORM : RANK_POS_NORM;
            EXC_INF:  r = sign ? RANK_NEG_INF : RANK_POS_INF;
            default:  r = RANK_NAN;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/slab_interval_reduce_if.sv
// Beat-in / result-out bundle of the slab reducer. Both sides use valid/ready: a transfer
// happens on a rising clk edge where valid && ready; the source holds its payload until then.
interface slab_interval_reduce_if
    import raabb_fp_pkg::*;
#(
    parameter int WIDTH = FP_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:0]   in_near;
    logic [WIDTH:0]   in_far;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_tmin;
    logic [WIDTH:0]   out_tmax;
    logic             out_hit;
    logic             out_nan;

    modport master (
        output in_valid, in_near, in_far, out_ready,
        input  in_ready, out_valid, out_tmin, out_tmax, out_hit, out_nan
    );

    modport slave (
        input  in_valid, in_near, in_far, out_ready,
        output in_ready, out_valid, out_tmin, out_tmax, out_hit, out_nan
    );
endinterface

// File: rtl/fp_order_le.sv
// Combinational total-order test le = (a <= b) on the exception-tagged FP word:
// class rank first, then magnitude, with the magnitude sense flipped for negative normals.
module fp_order_le
    import raabb_fp_pkg::*;
#(
    parameter int WE = FP_WE,
    parameter int WF = FP_WF
) (
    input  logic [WE+WF+2:0] a,
    input  logic [WE+WF+2:0] b,
    output logic             le
);
    localparam int WIDTH = WE + WF + 2;

    logic [2:0]       w_rank_a;
    logic [2:0]       w_rank_b;
    logic [WE+WF-1:0] w_mag_a;
    logic [WE+WF-1:0] w_mag_b;

    always_comb begin
        w_rank_a = fp_rank(a[WIDTH:WIDTH-1], a[WIDTH-2]);
        w_rank_b = fp_rank(b[WIDTH:WIDTH-1], b[WIDTH-2]);
        w_mag_a  = {a[WF+WE-1:WF], a[WF-1:0]};
        w_mag_b  = {b[WF+WE-1:WF], b[WF-1:0]};
        if (w_rank_a != w_rank_b) begin
            le = (w_rank_a < w_rank_b);
        end else if (w_rank_a == RANK_NEG_NORM) begin
            le = (w_mag_a >= w_mag_b);
        end else if (w_rank_a == RANK_POS_NORM) begin
            le = (w_mag_a <= w_mag_b);
        end else begin
            le = 1'b1;
        end
    end
endmodule

// File: rtl/slab_interval_reduce.sv
// Reduces three per-axis slab intervals to [max near, min far] and a hit flag.
// Optional macro SLAB_NAN_FLAG_EN adds a sticky per-transaction NaN flag that also vetoes hit.
module slab_interval_reduce
    import raabb_fp_pkg::*;
#(
    parameter int WE    = FP_WE,
    parameter int WF    = FP_WF,
    parameter int WIDTH = WE + WF + 2
) (
    input  logic                   clk,
    input  logic                   rst,
    slab_interval_reduce_if.slave  bus,
    output state_t                 o_dbg_state,
    output logic [1:0]             o_dbg_cnt
);
    localparam logic [WIDTH:0] ZERO_WORD = '0;

    state_t         r_state;
    logic [1:0]     r_cnt;
    logic [WIDTH:0] r_acc_near;
    logic [WIDTH:0] r_acc_far;

    logic w_accept;
    logic w_emit;
    logic w_in_near_le_acc;
    logic w_acc_far_le_in;
    logic w_tmin_le_tmax;
    logic w_zero_le_tmax;
    logic w_nan_flag;

    assign w_emit   = (r_state == ST_EMIT);
    assign w_accept = bus.in_valid && !w_emit;

    // Keep the stored near unless the new one is strictly greater, so ties keep the older word.
    fp_order_le #(.WE(WE), .WF(WF)) u_near_ord (
        .a (bus.in_near),
        .b (r_acc_near),
        .le(w_in_near_le_acc)
    );

    fp_order_le #(.WE(WE), .WF(WF)) u_far_ord (
        .a (r_acc_far),
        .b (bus.in_far),
        .le(w_acc_far_le_in)
    );

    fp_order_le #(.WE(WE), .WF(WF)) u_hit_ord (
        .a (r_acc_near),
        .b (r_acc_far),
        .le(w_tmin_le_tmax)
    );

    fp_order_le #(.WE(WE), .WF(WF)) u_hit_pos (
        .a (ZERO_WORD),
        .b (r_acc_far),
        .le(w_zero_le_tmax)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_ACC;
            r_cnt      <= 2'd0;
            r_acc_near <= '0;
            r_acc_far  <= '0;
        end else if (!w_emit) begin
            if (w_accept) begin
                if (r_cnt == 2'd0) begin
                    r_acc_near <= bus.in_near;
                    r_acc_far  <= bus.in_far;
                end else begin
                    if (!w_in_near_le_acc) r_acc_near <= bus.in_near;
                    if (!w_acc_far_le_in)  r_acc_far  <= bus.in_far;
                end
                if (r_cnt == 2'd2) begin
                    r_state <= ST_EMIT;
                    r_cnt   <= 2'd0;
                end else begin
                    r_cnt <= r_cnt + 2'd1;
                end
            end
        end else if (bus.out_ready) begin
            r_state <= ST_ACC;
        end
    end

`ifdef SLAB_NAN_FLAG_EN
    logic r_nan_flag;
    logic w_in_nan;

    assign w_in_nan = (bus.in_near[WIDTH:WIDTH-1] == EXC_NAN) ||
                      (bus.in_far[WIDTH:WIDTH-1] == EXC_NAN);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_nan_flag <= 1'b0;
        end else if (w_accept) begin
            r_nan_flag <= (r_cnt == 2'd0) ? w_in_nan : (r_nan_flag || w_in_nan);
        end
    end

    assign w_nan_flag = r_nan_flag;
`else
    assign w_nan_flag = 1'b0;
`endif

    assign bus.in_ready  = !w_emit;
    assign bus.out_valid = w_emit;
    assign bus.out_tmin  = r_acc_near;
    assign bus.out_tmax  = r_acc_far;
    assign bus.out_hit   = w_emit && w_tmin_le_tmax && w_zero_le_tmax && !w_nan_flag;
    assign bus.out_nan   = w_emit && w_nan_flag;

    assign o_dbg_state = r_state;
    assign o_dbg_cnt   = r_cnt;
endmodule

// File: tb/tb_slab_interval_reduce.sv
// Directed plus randomized bench for slab_interval_reduce; expected results come from a
// real-valued ordering model and are queued per transaction.
module tb_slab_interval_reduce;
    import raabb_fp_pkg::*;

    localparam int WE    = 11;
    localparam int WF    = 11;
    localparam int WIDTH = WE + WF + 2;
    localparam int BIAS  = (1 << (WE - 1)) - 1;
    localparam int W     = 2 * (WIDTH + 1) + 2;

    typedef logic [WIDTH:0] word_t;

    logic   clk;
    logic   rst;
    state_t dbg_state;
    logic [1:0] dbg_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];

    slab_interval_reduce_if #(.WIDTH(WIDTH)) bus ();

    slab_interval_reduce #(.WE(WE), .WF(WF), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .o_dbg_state(dbg_state),
        .o_dbg_cnt  (dbg_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- checks ----------------
    task automatic check_w(input string tag, input word_t obs, input word_t exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_i(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- value helpers / reference model ----------------
    function automatic word_t fp_of(input real r);
        real  m;
        int   e;
        logic s;
        if (r == 0.0) return '0;
        s = (r < 0.0);
        m = s ? -r : r;
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        return {2'b01, s, WE'(e + BIAS), WF'(int'((m - 1.0) * (2.0 ** WF)))};
    endfunction

    function automatic word_t inf_of(input logic s);
        return {2'b10, s, {(WE + WF){1'b0}}};
    endfunction

    function automatic logic is_nan(input word_t w);
        return (w[WIDTH:WIDTH-1] == 2'b11);
    endfunction

    // Class: 0 = -inf, 1 = finite (ordered by real value), 2 = +inf, 3 = NaN.
    function automatic int ref_class(input word_t w);
        case (w[WIDTH:WIDTH-1])
            2'b00, 2'b01: return 1;
            2'b10:        return w[WIDTH-2] ? 0 : 2;
            default:      return 3;
        endcase
    endfunction

    function automatic real ref_value(input word_t w);
        real m;
        int  e;
        if (w[WIDTH:WIDTH-1] != 2'b01) return 0.0;
        m = 1.0 + real'(w[WF-1:0]) / (2.0 ** WF);
        e = int'(w[WF+WE-1:WF]) - BIAS;
        m = m * (2.0 ** e);
        return w[WIDTH-2] ? -m : m;
    endfunction

    function automatic logic ref_le(input word_t a, input word_t b);
        int ca = ref_class(a);
        int cb = ref_class(b);
        if (ca != cb) return ca < cb;
        if (ca == 1)  return ref_value(a) <= ref_value(b);
        return 1'b1;
    endfunction

    function automatic logic [W-1:0] model_txn(input word_t n0, input word_t f0,
                                               input word_t n1, input word_t f1,
                                               input word_t n2, input word_t f2);
        word_t near_v[3];
        word_t far_v[3];
        word_t tmin, tmax;
        logic  hit, nan_seen, nan_out;
        near_v = '{n0, n1, n2};
        far_v  = '{f0, f1, f2};
        tmin = near_v[0];
        tmax = far_v[0];
        nan_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0 && !ref_le(near_v[i], tmin)) tmin = near_v[i];
            if (i > 0 && !ref_le(tmax, far_v[i]))  tmax = far_v[i];
            nan_seen = nan_seen | is_nan(near_v[i]) | is_nan(far_v[i]);
        end
        hit = ref_le(tmin, tmax) && ref_le('0, tmax);
`ifdef SLAB_NAN_FLAG_EN
        nan_out = nan_seen;
        if (nan_seen) hit = 1'b0;
`else
        nan_out = 1'b0;
`endif
        return {tmin, tmax, hit, nan_out};
    endfunction

    function automatic word_t rand_word();
        word_t w;
        int    cls;
        w   = word_t'($urandom);
        cls = $urandom_range(0, 11);
        case (cls)
            0:       w[WIDTH:WIDTH-1] = 2'b00;
            1:       w[WIDTH:WIDTH-1] = 2'b10;
            2:       w[WIDTH:WIDTH-1] = 2'b11;
            default: begin
                w[WIDTH:WIDTH-1] = 2'b01;
                w[WF+WE-1:WF]    = WE'(BIAS - 3 + $urandom_range(0, 6));
                if ($urandom_range(0, 1) == 0) w[WF-1:0] = WF'($urandom_range(0, 3) << (WF - 2));
            end
        endcase
        return w;
    endfunction

    // ---------------- driver tasks ----------------
    // All tasks start and end #1 after a rising edge.
    task automatic do_reset();
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic send_beat(input string tag, input word_t n, input word_t f);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_near  = n;
        bus.in_far   = f;
        while (!bus.in_ready && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check_b({tag, "_in_ready_timeout"}, bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send3(input string tag, input logic rnd,
                         input word_t n0, input word_t f0,
                         input word_t n1, input word_t f1,
                         input word_t n2, input word_t f2);
        word_t nv[3];
        word_t fv[3];
        nv = '{n0, n1, n2};
        fv = '{f0, f1, f2};
        exp_q.push_back(model_txn(n0, f0, n1, f1, n2, f2));
        for (int i = 0; i < 3; i++) begin
            if (rnd) begin
                int gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk);
                    #1;
                    check_i({tag, "_idle_cnt"}, int'(dbg_cnt), i);
                end
            end
            if (i == 2) check_b({tag, "_valid_early"}, bus.out_valid, 1'b0);
            send_beat(tag, nv[i], fv[i]);
        end
        check_b({tag, "_valid_latency"}, bus.out_valid, 1'b1);
        check_b({tag, "_in_ready_emit"}, bus.in_ready, 1'b0);
    endtask

    task automatic check_result(input string tag);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            check_i({tag, "_queue_empty"}, 0, 1);
            return;
        end
        e = exp_q.pop_front();
        check_w({tag, "_tmin"}, bus.out_tmin, e[W-1 -: WIDTH+1]);
        check_w({tag, "_tmax"}, bus.out_tmax, e[WIDTH+2 -: WIDTH+1]);
        check_b({tag, "_hit"},  bus.out_hit,  e[1]);
        check_b({tag, "_nan"},  bus.out_nan,  e[0]);
    endtask

    task automatic handshake(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check_b({tag, "_valid_drop"}, bus.out_valid, 1'b0);
        check_b({tag, "_ready_back"}, bus.in_ready, 1'b1);
    endtask

    task automatic check_reset_state(input string tag);
        check_b({tag, "_out_valid"}, bus.out_valid, 1'b0);
        check_b({tag, "_in_ready"},  bus.in_ready, 1'b1);
        check_w({tag, "_tmin"},      bus.out_tmin, '0);
        check_w({tag, "_tmax"},      bus.out_tmax, '0);
        check_b({tag, "_hit"},       bus.out_hit, 1'b0);
        check_b({tag, "_nan"},       bus.out_nan, 1'b0);
        check_i({tag, "_cnt"},       int'(dbg_cnt), 0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        bus.in_valid  = 1'b0;
        bus.in_near   = '0;
        bus.in_far    = '0;
        bus.out_ready = 1'b0;
        do_reset();
        check_reset_state("reset");

        // Overlapping intervals.
        send3("basic", 1'b0, fp_of(1.0), fp_of(5.0), fp_of(2.0), fp_of(4.0), fp_of(0.5), fp_of(6.0));
        check_w("basic_tmin_const", bus.out_tmin, fp_of(2.0));
        check_w("basic_tmax_const", bus.out_tmax, fp_of(4.0));
        check_b("basic_hit_const",  bus.out_hit, 1'b1);
        check_result("basic");
        handshake("basic");

        // Disjoint intervals.
        send3("miss", 1'b0, fp_of(1.0), fp_of(2.0), fp_of(3.0), fp_of(4.0), fp_of(0.0), fp_of(9.0));
        check_w("miss_tmin_const", bus.out_tmin, fp_of(3.0));
        check_w("miss_tmax_const", bus.out_tmax, fp_of(2.0));
        check_b("miss_hit_const",  bus.out_hit, 1'b0);
        check_result("miss");
        handshake("miss");

        // Box behind the origin, with infinities on one axis.
        send3("behind", 1'b0, fp_of(-3.0), fp_of(-1.0), inf_of(1'b1), inf_of(1'b0),
              fp_of(-5.0), fp_of(-0.5));
        check_w("behind_tmax_const", bus.out_tmax, fp_of(-1.0));
        check_b("behind_hit_const",  bus.out_hit, 1'b0);
        check_result("behind");
        handshake("behind");

        // tmax exactly +0 still counts as a hit.
        send3("zero_edge", 1'b0, fp_of(-2.0), fp_of(0.0), fp_of(-4.0), fp_of(1.0),
              fp_of(-3.0), fp_of(0.0));
        check_w("zero_edge_tmin_const", bus.out_tmin, fp_of(-2.0));
        check_w("zero_edge_tmax_const", bus.out_tmax, fp_of(0.0));
        check_b("zero_edge_hit_const",  bus.out_hit, 1'b1);
        check_result("zero_edge");
        handshake("zero_edge");

        // Back-pressure: result held, next beat blocked until after the handshake cycle.
        send3("hold", 1'b0, fp_of(1.0), fp_of(5.0), fp_of(2.0), fp_of(4.0), fp_of(0.5), fp_of(6.0));
        bus.in_valid = 1'b1;
        bus.in_near  = fp_of(3.0);
        bus.in_far   = fp_of(7.0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check_b("hold_in_ready", bus.in_ready, 1'b0);
            check_b("hold_valid",    bus.out_valid, 1'b1);
            check_w("hold_tmin",     bus.out_tmin, fp_of(2.0));
            check_w("hold_tmax",     bus.out_tmax, fp_of(4.0));
        end
        check_result("hold");
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check_b("hold_valid_drop", bus.out_valid, 1'b0);
        check_i("hold_no_accept",  int'(dbg_cnt), 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check_i("hold_accept_next", int'(dbg_cnt), 1);
        do_reset();
        check_reset_state("hold_reset");

        // Reset in the middle of a transaction discards the partial accumulation.
        send_beat("partial", fp_of(8.0), fp_of(9.0));
        send_beat("partial", fp_of(7.0), fp_of(8.5));
        do_reset();
        check_reset_state("mid_reset");
        send3("after_reset", 1'b0, fp_of(1.0), fp_of(3.0), fp_of(0.5), fp_of(2.0),
              fp_of(1.5), fp_of(4.0));
        check_w("after_reset_tmin_const", bus.out_tmin, fp_of(1.5));
        check_w("after_reset_tmax_const", bus.out_tmax, fp_of(2.0));
        check_result("after_reset");
        handshake("after_reset");

        // Reset while a result is pending, no out_ready given.
        send3("emit_reset", 1'b0, fp_of(1.0), fp_of(2.0), fp_of(1.0), fp_of(2.0),
              fp_of(1.0), fp_of(2.0));
        check_result("emit_reset");
        do_reset();
        check_reset_state("emit_reset_after");

`ifdef SLAB_NAN_FLAG_EN
        send3("nan_txn", 1'b0, fp_of(1.0), fp_of(5.0), fp_of(2.0), {2'b11, {(WIDTH-1){1'b0}}},
              fp_of(0.5), fp_of(6.0));
        check_b("nan_flag_const", bus.out_nan, 1'b1);
        check_b("nan_hit_const",  bus.out_hit, 1'b0);
        check_result("nan_txn");
        handshake("nan_txn");
        send3("nan_clean", 1'b0, fp_of(1.0), fp_of(5.0), fp_of(2.0), fp_of(4.0),
              fp_of(0.5), fp_of(6.0));
        check_b("nan_clean_const", bus.out_nan, 1'b0);
        check_b("nan_clean_hit",   bus.out_hit, 1'b1);
        check_result("nan_clean");
        handshake("nan_clean");
`endif

        // Randomized transactions with idle gaps and consumer stalls.
        for (int t = 0; t < 60; t++) begin
            int stall;
            send3("rand", 1'b1, rand_word(), rand_word(), rand_word(), rand_word(),
                  rand_word(), rand_word());
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                @(posedge clk);
                #1;
                check_b("rand_stall_in_ready", bus.in_ready, 1'b0);
            end
            check_result("rand");
            handshake("rand");
        end

        check_i("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
